// File: rtl/id_inst_queue.sv
// DEPTH-entry instruction queue between fetch and decode.
// Presents NOP_INST to decode whenever the queue is empty.
module id_inst_queue #(
   parameter int                DEPTH    = 4,
   parameter int                INST_W   = 32,
   parameter int                PC_W     = 30,
   parameter logic [INST_W-1:0] NOP_INST = 32'h0000_0013
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         flush,
   input  logic                         if_valid,
   output logic                         if_ready,
   input  logic [INST_W-1:0]            if_inst,
   input  logic [PC_W-1:0]              if_pc,
   output logic                         id_valid,
   input  logic                         id_ready,
   output logic [INST_W-1:0]            id_inst,
   output logic [PC_W-1:0]              id_pc,
   output logic [$clog2(DEPTH+1)-1:0]   count
);

   localparam int             AW       = $clog2(DEPTH);
   localparam int             CW       = $clog2(DEPTH+1);
   localparam logic [CW-1:0]  FULL_CNT = CW'(DEPTH);

   logic [INST_W-1:0] r_mem_inst [DEPTH];
   logic [PC_W-1:0]   r_mem_pc   [DEPTH];
   logic [AW-1:0]     r_wr_ptr;
   logic [AW-1:0]     r_rd_ptr;
   logic [CW-1:0]     r_count;

   logic              w_push;
   logic              w_pop;

   // Ready depends only on occupancy, so a full queue refuses fetch even while decode pops.
   assign if_ready = (r_count != FULL_CNT);
   assign id_valid = (r_count != '0);
   assign w_push   = if_valid && if_ready;
   assign w_pop    = id_valid && id_ready;

   assign id_inst  = id_valid ? r_mem_inst[r_rd_ptr] : NOP_INST;
   assign id_pc    = r_mem_pc[r_rd_ptr];
   assign count    = r_count;

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // Storage carries no reset; a push coinciding with flush or reset is dropped.
   always_ff @(posedge clk) begin
      if (w_push && !flush && !rst) begin
         r_mem_inst[r_wr_ptr] <= if_inst;
         r_mem_pc[r_wr_ptr]   <= if_pc;
      end
   end

endmodule

// File: tb/tb_id_inst_queue.sv
// Bench for id_inst_queue: directed vector table, hand-written corner sequences,
// and randomized traffic against a queue-based reference model.
module tb_id_inst_queue;

   localparam int DEPTH = 4;
   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        rst, flush, if_valid, if_ready, id_valid, id_ready;
   logic [31:0] if_inst, id_inst;
   logic [29:0] if_pc, id_pc;
   logic [2:0]  count;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   id_inst_queue #(.DEPTH(DEPTH), .INST_W(32), .PC_W(30), .NOP_INST(NOP)) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .if_valid(if_valid), .if_ready(if_ready), .if_inst(if_inst), .if_pc(if_pc),
      .id_valid(id_valid), .id_ready(id_ready), .id_inst(id_inst), .id_pc(id_pc),
      .count(count)
   );

   typedef struct {
      logic        rst, flush, ifv;
      logic [31:0] inst;
      logic [29:0] pc;
      logic        idr;
      logic        chk;
      logic        ev, er;
      logic [2:0]  ec;
      logic [31:0] ei;
      logic [29:0] ep;
   } vec_t;

   typedef struct {
      logic [31:0] inst;
      logic [29:0] pc;
   } ent_t;

   vec_t tbl[$];
   ent_t mq[$];

   function automatic vec_t v(logic r, logic f, logic ifv, logic [31:0] inst, logic [29:0] pc,
                              logic idr, logic chk, logic ev, logic er, logic [2:0] ec,
                              logic [31:0] ei, logic [29:0] ep);
      vec_t t;
      t.rst = r; t.flush = f; t.ifv = ifv; t.inst = inst; t.pc = pc; t.idr = idr;
      t.chk = chk; t.ev = ev; t.er = er; t.ec = ec; t.ei = ei; t.ep = ep;
      return t;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h at t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic drive(input logic r, input logic f, input logic ifv, input logic [31:0] inst,
                        input logic [29:0] pc, input logic idr);
      rst = r; flush = f; if_valid = ifv; if_inst = inst; if_pc = pc; id_ready = idr;
   endtask

   task automatic check_outs(input string tag, input logic ev, input logic er,
                             input logic [2:0] ec, input logic [31:0] ei, input logic [29:0] ep);
      chk({tag, ".id_valid"}, 64'(id_valid), 64'(ev));
      chk({tag, ".if_ready"}, 64'(if_ready), 64'(er));
      chk({tag, ".count"},    64'(count),    64'(ec));
      chk({tag, ".id_inst"},  64'(id_inst),  64'(ei));
      if (ev) chk({tag, ".id_pc"}, 64'(id_pc), 64'(ep));
   endtask

   // Reference model step: check outputs against queue contents, then advance.
   task automatic model_cycle(input logic r, input logic f, input logic ifv, input logic [31:0] inst,
                              input logic [29:0] pc, input logic idr);
      bit   push, pop;
      ent_t e;
      @(negedge clk);
      drive(r, f, ifv, inst, pc, idr);
      #1;
      if (mq.size() == 0)
         check_outs("rand", 1'b0, 1'b1, 3'd0, NOP, 30'd0);
      else
         check_outs("rand", 1'b1, mq.size() < DEPTH, 3'(mq.size()), mq[0].inst, mq[0].pc);
      push = ifv && (mq.size() < DEPTH);
      pop  = idr && (mq.size() > 0);
      @(posedge clk);
      if (r || f) mq.delete();
      else begin
         if (pop) void'(mq.pop_front());
         if (push) begin
            e.inst = inst; e.pc = pc;
            mq.push_back(e);
         end
      end
   endtask

   initial begin
      drive(1'b1, 1'b0, 1'b0, '0, '0, 1'b0);

      // reset with fetch active
      tbl.push_back(v(1,0,1,32'hAAAA_AAAA,30'h5,  0, 0, 0,1,0,NOP,0));
      tbl.push_back(v(1,0,1,32'hAAAA_AAAA,30'h5,  0, 1, 0,1,0,NOP,0));
      tbl.push_back(v(0,0,0,32'h0,30'h0,          0, 1, 0,1,0,NOP,0));
      // single push, held while stalled
      tbl.push_back(v(0,0,1,32'h0050_0093,30'h100,0, 1, 0,1,0,NOP,0));
      tbl.push_back(v(0,0,0,32'h0,30'h0,          0, 1, 1,1,1,32'h0050_0093,30'h100));
      tbl.push_back(v(0,0,0,32'h0,30'h0,          0, 1, 1,1,1,32'h0050_0093,30'h100));
      tbl.push_back(v(0,0,0,32'h0,30'h0,          1, 1, 1,1,1,32'h0050_0093,30'h100));
      tbl.push_back(v(0,0,0,32'h0,30'h0,          0, 1, 0,1,0,NOP,0));
      // fill to full, refuse a fifth, drain in order
      tbl.push_back(v(0,0,1,32'hA1,30'h10,        0, 1, 0,1,0,NOP,0));
      tbl.push_back(v(0,0,1,32'hA2,30'h11,        0, 1, 1,1,1,32'hA1,30'h10));
      tbl.push_back(v(0,0,1,32'hA3,30'h12,        0, 1, 1,1,2,32'hA1,30'h10));
      tbl.push_back(v(0,0,1,32'hA4,30'h13,        0, 1, 1,1,3,32'hA1,30'h10));
      tbl.push_back(v(0,0,1,32'hDEAD,30'h3F,      0, 1, 1,0,4,32'hA1,30'h10));
      tbl.push_back(v(0,0,0,32'h0,30'h0,          1, 1, 1,0,4,32'hA1,30'h10));
      tbl.push_back(v(0,0,0,32'h0,30'h0,          1, 1, 1,1,3,32'hA2,30'h11));
      tbl.push_back(v(0,0,0,32'h0,30'h0,          1, 1, 1,1,2,32'hA3,30'h12));
      tbl.push_back(v(0,0,0,32'h0,30'h0,          1, 1, 1,1,1,32'hA4,30'h13));
      tbl.push_back(v(0,0,0,32'h0,30'h0,          1, 1, 0,1,0,NOP,0));
      // full with simultaneous pop: push refused
      tbl.push_back(v(0,0,1,32'hB1,30'h20,        0, 1, 0,1,0,NOP,0));
      tbl.push_back(v(0,0,1,32'hB2,30'h21,        0, 1, 1,1,1,32'hB1,30'h20));
      tbl.push_back(v(0,0,1,32'hB3,30'h22,        0, 1, 1,1,2,32'hB1,30'h20));
      tbl.push_back(v(0,0,1,32'hB4,30'h23,        0, 1, 1,1,3,32'hB1,30'h20));
      tbl.push_back(v(0,0,1,32'hC5,30'h24,        1, 1, 1,0,4,32'hB1,30'h20));
      tbl.push_back(v(0,0,0,32'h0,30'h0,          0, 1, 1,1,3,32'hB2,30'h21));
      // flush mid-stream with push and pop requested
      tbl.push_back(v(0,1,1,32'hEE,30'h2F,        1, 1, 1,1,3,32'hB2,30'h21));
      tbl.push_back(v(0,0,1,32'hF0,30'h200,       0, 1, 0,1,0,NOP,0));
      tbl.push_back(v(0,0,0,32'h0,30'h0,          0, 1, 1,1,1,32'hF0,30'h200));
      tbl.push_back(v(0,0,0,32'h0,30'h0,          1, 1, 1,1,1,32'hF0,30'h200));
      tbl.push_back(v(0,0,0,32'h0,30'h0,          0, 1, 0,1,0,NOP,0));

      for (int i = 0; i < tbl.size(); i++) begin
         @(negedge clk);
         drive(tbl[i].rst, tbl[i].flush, tbl[i].ifv, tbl[i].inst, tbl[i].pc, tbl[i].idr);
         #1;
         if (tbl[i].chk)
            check_outs($sformatf("vec%0d", i), tbl[i].ev, tbl[i].er, tbl[i].ec, tbl[i].ei, tbl[i].ep);
         @(posedge clk);
      end

      // streaming across pointer wrap: pc 0..9 with continuous push and pop
      for (int i = 0; i < 11; i++) begin
         @(negedge clk);
         drive(1'b0, 1'b0, i < 10, 32'h1000 + 32'(i), 30'(i), 1'b1);
         #1;
         if (i == 0) check_outs($sformatf("stream%0d", i), 1'b0, 1'b1, 3'd0, NOP, 30'd0);
         else        check_outs($sformatf("stream%0d", i), 1'b1, 1'b1, 3'd1, 32'h1000 + 32'(i-1), 30'(i-1));
         @(posedge clk);
      end
      @(negedge clk);
      drive(1'b0, 1'b0, 1'b0, '0, '0, 1'b0);
      #1;
      check_outs("stream_end", 1'b0, 1'b1, 3'd0, NOP, 30'd0);
      @(posedge clk);

      // reset mid-operation drops queued entries
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         drive(1'b0, 1'b0, 1'b1, 32'h77 + 32'(i), 30'h300 + 30'(i), 1'b0);
         @(posedge clk);
      end
      @(negedge clk);
      drive(1'b1, 1'b0, 1'b1, 32'h99, 30'h399, 1'b1);
      #1;
      check_outs("pre_rst", 1'b1, 1'b1, 3'd2, 32'h77, 30'h300);
      @(posedge clk);
      @(negedge clk);
      drive(1'b0, 1'b0, 1'b0, '0, '0, 1'b0);
      #1;
      check_outs("post_rst", 1'b0, 1'b1, 3'd0, NOP, 30'd0);
      @(posedge clk);

      // randomized traffic against the queue model (state is empty here)
      mq.delete();
      for (int i = 0; i < 3000; i++) begin
         logic r, f;
         r = ($urandom_range(0, 199) == 0);
         f = ($urandom_range(0, 59) == 0);
         model_cycle(r, f, $urandom_range(0, 3) != 0, $urandom, 30'($urandom),
                     $urandom_range(0, 2) != 0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
